// File: rtl/uart_transceiver_if.sv
// Byte-stream side of uart_transceiver: ready/valid transmit and receive channels.
// The slave modport is the transceiver; the master modport is the on-chip producer/consumer.
interface uart_transceiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_overrun
  );
endinterface

// File: rtl/uart_transceiver.sv
// Parametrised full-duplex UART (5-9 data bits, none/odd/even parity, 1/2 stop bits)
// with false-start rejection, parity/framing error flags and receive overrun detection.
module uart_transceiver #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int SYNC_DEPTH = 3,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  uart_transceiver_if.slave  bus,
  output logic               uart_tx,
  input  logic               uart_rx
);
  localparam int BAUD_DIV = CLK_HZ / BAUDRATE;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int IW       = 4;
  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(BAUD_DIV / 2);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t            tx_state, tx_state_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [IW-1:0]        tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_par, tx_par_n;
  logic                 tx_line_n;
  logic                 tx_bit_end;

  assign tx_bit_end   = (tx_cnt == CNT_LAST);
  assign bus.tx_ready = (tx_state == TX_IDLE);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_line_n  = 1'b1;
    if (tx_state != TX_IDLE) tx_cnt_n = tx_bit_end ? '0 : tx_cnt + 1'b1;
    unique case (tx_state)
      TX_IDLE: if (bus.tx_valid) begin
        tx_state_n = TX_START;
        tx_cnt_n   = '0;
        tx_shift_n = bus.tx_data;
        tx_par_n   = (PARITY == 1) ? ~^bus.tx_data : ^bus.tx_data;
      end
      TX_START: if (tx_bit_end) begin
        tx_state_n = TX_DATA;
        tx_idx_n   = '0;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_shift_n = tx_shift >> 1;
        if (tx_idx == DATA_LAST) begin
          tx_idx_n   = '0;
          tx_state_n = (PARITY == 0) ? TX_STOP : TX_PARITY;
        end else begin
          tx_idx_n = tx_idx + 1'b1;
        end
      end
      TX_PARITY: if (tx_bit_end) tx_state_n = TX_STOP;
      TX_STOP: if (tx_bit_end) begin
        if (tx_idx == STOP_LAST) begin
          tx_state_n = TX_IDLE;
          tx_idx_n   = '0;
        end else begin
          tx_idx_n = tx_idx + 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    // Line level is decoded from the next state so uart_tx is a clean flop output.
    case (tx_state_n)
      TX_START:  tx_line_n = 1'b0;
      TX_DATA:   tx_line_n = tx_shift_n[0];
      TX_PARITY: tx_line_n = tx_par_n;
      default:   tx_line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      uart_tx  <= tx_line_n;
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  logic [SYNC_DEPTH-1:0] sync;
  logic                  rxs;
  rx_state_t             rx_state, rx_state_n;
  logic [CW-1:0]         rx_cnt, rx_cnt_n;
  logic [IW-1:0]         rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0]  rx_shift, rx_shift_n;
  logic                  rx_perr, rx_perr_n, rx_ferr, rx_ferr_n;
  logic                  rx_armed, rx_armed_n;
  logic                  frame_done, load;
  logic [DATA_BITS-1:0]  data_q;
  logic                  perr_q, ferr_q, valid_q, overrun_q;

  assign rxs = sync[SYNC_DEPTH-1];

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_perr_n  = rx_perr;
    rx_ferr_n  = rx_ferr;
    rx_armed_n = rx_armed | rxs;
    frame_done = 1'b0;
    unique case (rx_state)
      RX_IDLE: if (!rxs && rx_armed) begin
        rx_state_n = RX_START;
        rx_cnt_n   = '0;
      end
      RX_START: if (rx_cnt == CNT_MID) begin
        rx_cnt_n = '0;
        if (rxs) begin
          rx_state_n = RX_IDLE;
        end else begin
          rx_state_n = RX_DATA;
          rx_idx_n   = '0;
          rx_perr_n  = 1'b0;
          rx_ferr_n  = 1'b0;
        end
      end else begin
        rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_DATA: if (rx_cnt == CNT_LAST) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rxs, rx_shift[DATA_BITS-1:1]};
        if (rx_idx == DATA_LAST) begin
          rx_idx_n   = '0;
          rx_state_n = (PARITY == 0) ? RX_STOP : RX_PARITY;
        end else begin
          rx_idx_n = rx_idx + 1'b1;
        end
      end else begin
        rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_PARITY: if (rx_cnt == CNT_LAST) begin
        rx_cnt_n   = '0;
        rx_perr_n  = (PARITY == 1) ? ~(^rx_shift ^ rxs) : (^rx_shift ^ rxs);
        rx_state_n = RX_STOP;
      end else begin
        rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_STOP: if (rx_cnt == CNT_LAST) begin
        rx_cnt_n  = '0;
        rx_ferr_n = rx_ferr | ~rxs;
        if (rx_idx == STOP_LAST) begin
          rx_state_n = RX_IDLE;
          rx_idx_n   = '0;
          frame_done = 1'b1;
          // A low final stop bit must see the line go high before a new start is accepted.
          rx_armed_n = rxs;
        end else begin
          rx_idx_n = rx_idx + 1'b1;
        end
      end else begin
        rx_cnt_n = rx_cnt + 1'b1;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign load = frame_done && (!valid_q || bus.rx_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      rx_perr   <= 1'b0;
      rx_ferr   <= 1'b0;
      rx_armed  <= 1'b1;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_DEPTH-2:0], uart_rx};
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_idx    <= rx_idx_n;
      rx_shift  <= rx_shift_n;
      rx_perr   <= rx_perr_n;
      rx_ferr   <= rx_ferr_n;
      rx_armed  <= rx_armed_n;
      overrun_q <= frame_done && valid_q && !bus.rx_ready;
      if (load) begin
        data_q  <= rx_shift_n;
        perr_q  <= rx_perr_n;
        ferr_q  <= rx_ferr_n;
        valid_q <= 1'b1;
      end else if (bus.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data       = data_q;
  assign bus.rx_parity_err = perr_q;
  assign bus.rx_frame_err  = ferr_q;
  assign bus.rx_valid      = valid_q;
  assign bus.rx_overrun    = overrun_q;
endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: random loopback in four frame formats against a
// word-queue reference, plus directed tx waveform, rx error table and multi-cycle corner cases.
module tb_uart_transceiver;
  localparam int CLK_HZ   = 1_000_000;
  localparam int BAUDRATE = 100_000;
  localparam int BAUD_DIV = CLK_HZ / BAUDRATE;
  localparam int SYNC     = 3;
  localparam int NWORDS   = 256;

  logic clk = 1'b0;
  logic rst;
  logic lb_go = 1'b0;
  int   lb_done = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- directed instances: 8N1 (a) and 8E1 (e) ----------------
  uart_transceiver_if #(.DATA_BITS(8)) bus_a ();
  uart_transceiver_if #(.DATA_BITS(8)) bus_e ();
  logic       tx_a, tx_e;
  logic [1:0] rxd;
  int         ovr_a = 0;

  uart_transceiver #(.CLK_HZ(CLK_HZ), .BAUDRATE(BAUDRATE), .SYNC_DEPTH(SYNC),
                     .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave), .uart_tx(tx_a), .uart_rx(rxd[0]));

  uart_transceiver #(.CLK_HZ(CLK_HZ), .BAUDRATE(BAUDRATE), .SYNC_DEPTH(SYNC),
                     .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    dut_e (.clk(clk), .rst(rst), .bus(bus_e.slave), .uart_tx(tx_e), .uart_rx(rxd[1]));

  always @(negedge clk) if (bus_a.rx_overrun === 1'b1) ovr_a++;

  // ---------------- loopback instances: 8N1, 7E2, 9O1, 5N2 ----------------
  for (genvar g = 0; g < 4; g++) begin : lb
    localparam int DB = (g == 0) ? 8 : (g == 1) ? 7 : (g == 2) ? 9 : 5;
    localparam int PB = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 1 : 0;
    localparam int SB = (g == 1 || g == 3) ? 2 : 1;

    uart_transceiver_if #(.DATA_BITS(DB)) bus ();
    logic          line;
    logic [DB-1:0] q[$];
    logic [DB-1:0] w, exp_w;
    int            ovr = 0;
    int            t_tx, t_rx;
    bit            rx_ok;

    uart_transceiver #(.CLK_HZ(CLK_HZ), .BAUDRATE(BAUDRATE), .SYNC_DEPTH(SYNC),
                       .DATA_BITS(DB), .PARITY(PB), .STOP_BITS(SB))
      dut (.clk(clk), .rst(rst), .bus(bus.slave), .uart_tx(line), .uart_rx(line));

    always @(negedge clk) if (bus.rx_overrun === 1'b1) ovr++;

    initial begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
      bus.rx_ready = 1'b1;
      wait (lb_go);
      @(negedge clk);
      fork
        begin : sender
          for (int k = 0; k < NWORDS; k++) begin
            w = DB'($urandom);
            bus.tx_valid = 1'b0;
            bus.tx_data  = DB'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.tx_data  = w;
            bus.tx_valid = 1'b1;
            t_tx = 0;
            while (bus.tx_ready !== 1'b1 && t_tx < 400) begin
              @(negedge clk);
              t_tx++;
            end
            if (t_tx >= 400) begin
              check($sformatf("lb%0d_tx_ready_timeout", g), 1, 0);
              break;
            end
            q.push_back(w);
            @(negedge clk);
          end
          bus.tx_valid = 1'b0;
        end
        begin : receiver
          rx_ok = 1'b1;
          for (int k = 0; k < NWORDS && rx_ok; k++) begin
            t_rx = 0;
            while (bus.rx_valid !== 1'b1 && t_rx < 400) begin
              @(negedge clk);
              t_rx++;
            end
            if (t_rx >= 400 || q.size() == 0) begin
              check($sformatf("lb%0d_rx_timeout", g), 1, 0);
              rx_ok = 1'b0;
            end else begin
              exp_w = q.pop_front();
              check($sformatf("lb%0d_data", g), bus.rx_data, exp_w);
              check($sformatf("lb%0d_perr", g), bus.rx_parity_err, 0);
              check($sformatf("lb%0d_ferr", g), bus.rx_frame_err, 0);
              @(negedge clk);
            end
          end
        end
      join
      check($sformatf("lb%0d_overrun", g), ovr, 0);
      lb_done++;
    end
  end

  // ---------------- helpers ----------------
  task automatic drive_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd[which] = bits[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    rxd[which] = 1'b1;
  endtask

  task automatic wait_valid(input int which, input string name);
    int t = 0;
    while (((which == 0) ? bus_a.rx_valid : bus_e.rx_valid) !== 1'b1 && t < 4 * BAUD_DIV) begin
      @(negedge clk);
      t++;
    end
    check(name, (which == 0) ? bus_a.rx_valid : bus_e.rx_valid, 1);
  endtask

  task automatic ack(input int which, input string name);
    if (which == 0) bus_a.rx_ready = 1'b1; else bus_e.rx_ready = 1'b1;
    @(negedge clk);
    bus_a.rx_ready = 1'b0;
    bus_e.rx_ready = 1'b0;
    check(name, (which == 0) ? bus_a.rx_valid : bus_e.rx_valid, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } rx_vec_t;

  rx_vec_t     vt[6];
  logic [9:0]  exp_frame;
  logic [15:0] fr;
  int          seen, t, ovr_base;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 8E1 receive table: even parity bit must equal XOR of the data bits
    vt[0] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[1] = '{8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[4] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[5] = '{8'h7F, 1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    rxd = 2'b11;
    bus_a.tx_valid = 1'b0; bus_a.tx_data = '0; bus_a.rx_ready = 1'b0;
    bus_e.tx_valid = 1'b0; bus_e.tx_data = '0; bus_e.rx_ready = 1'b0;
    repeat (5) @(negedge clk);

    check("rst_uart_tx", tx_a, 1);
    check("rst_tx_ready", bus_a.tx_ready, 1);
    check("rst_rx_valid", bus_a.rx_valid, 0);
    check("rst_rx_data", bus_a.rx_data, 0);
    check("rst_perr", bus_a.rx_parity_err, 0);
    check("rst_ferr", bus_a.rx_frame_err, 0);
    check("rst_overrun", bus_a.rx_overrun, 0);
    check("rst_e_uart_tx", tx_e, 1);
    rst = 1'b0;

    lb_go = 1'b1;
    t = 0;
    while (lb_done < 4 && t < 60000) begin
      @(negedge clk);
      t++;
    end
    check("lb_all_done", lb_done, 4);

    // 8N1 transmit of 0xA5; a pending request during the frame must not disturb it
    bus_a.tx_data  = 8'hA5;
    bus_a.tx_valid = 1'b1;
    check("tx_ready_idle", bus_a.tx_ready, 1);
    @(negedge clk);
    bus_a.tx_data = 8'h3C;
    exp_frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10 * BAUD_DIV; i++) begin
      check("tx_a5_line", tx_a, exp_frame[i / BAUD_DIV]);
      check("tx_a5_busy", bus_a.tx_ready, 0);
      @(negedge clk);
    end
    check("tx_a5_stop_end_line", tx_a, 1);
    check("tx_a5_ready_back", bus_a.tx_ready, 1);
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
    check("tx_back_to_back_start", tx_a, 0);
    repeat (10 * BAUD_DIV + 2) @(negedge clk);
    check("tx_3c_done", bus_a.tx_ready, 1);

    // 8E1 parity/framing table
    for (int i = 0; i < 6; i++) begin
      fr = {5'b0, vt[i].stop, vt[i].pbit, vt[i].data, 1'b0};
      drive_bits(1, fr, 11);
      wait_valid(1, "tbl_valid");
      check("tbl_data", bus_e.rx_data, {24'b0, vt[i].data});
      check("tbl_perr", bus_e.rx_parity_err, {31'b0, vt[i].exp_perr});
      check("tbl_ferr", bus_e.rx_frame_err, {31'b0, vt[i].exp_ferr});
      ack(1, "tbl_valid_drop");
      repeat (2 * BAUD_DIV) @(negedge clk);
    end

    // 8N1 framing error, then the line recovers and the next frame is clean
    drive_bits(0, {6'b0, 1'b0, 8'h5A, 1'b0}, 10);
    wait_valid(0, "ferr_valid");
    check("ferr_data", bus_a.rx_data, 8'h5A);
    check("ferr_flag", bus_a.rx_frame_err, 1);
    check("ferr_perr", bus_a.rx_parity_err, 0);
    ack(0, "ferr_valid_drop");
    seen = 0;
    for (int i = 0; i < 2 * BAUD_DIV; i++) begin
      if (bus_a.rx_valid === 1'b1) seen++;
      @(negedge clk);
    end
    check("ferr_no_retrigger", seen, 0);
    drive_bits(0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10);
    wait_valid(0, "recover_valid");
    check("recover_data", bus_a.rx_data, 8'hC3);
    check("recover_ferr", bus_a.rx_frame_err, 0);
    ack(0, "recover_valid_drop");

    // 3-cycle glitch is rejected and the receiver is ready for a frame right after
    rxd[0] = 1'b0;
    repeat (3) @(negedge clk);
    rxd[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < BAUD_DIV / 2 + SYNC + 1; i++) begin
      if (bus_a.rx_valid === 1'b1) seen++;
      @(negedge clk);
    end
    check("glitch_no_valid", seen, 0);
    drive_bits(0, {6'b0, 1'b1, 8'h96, 1'b0}, 10);
    wait_valid(0, "post_glitch_valid");
    check("post_glitch_data", bus_a.rx_data, 8'h96);
    check("post_glitch_ferr", bus_a.rx_frame_err, 0);
    ack(0, "post_glitch_drop");
    repeat (BAUD_DIV) @(negedge clk);

    // overrun: consumer stalled across two frames
    drive_bits(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
    wait_valid(0, "ovr_first_valid");
    check("ovr_first_data", bus_a.rx_data, 8'h11);
    ovr_base = ovr_a;
    drive_bits(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
    repeat (5) @(negedge clk);
    check("ovr_pulse_count", ovr_a - ovr_base, 1);
    check("ovr_data_held", bus_a.rx_data, 8'h11);
    check("ovr_valid_held", bus_a.rx_valid, 1);
    ack(0, "ovr_valid_drop");

    // reset in the middle of a transmitted start bit
    bus_a.tx_data  = 8'h00;
    bus_a.tx_valid = 1'b1;
    check("rst_tx_ready_pre", bus_a.tx_ready, 1);
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midtx_start_low", tx_a, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midtx_rst_line_high", tx_a, 1);
    check("midtx_rst_ready", bus_a.tx_ready, 1);
    check("midtx_rst_rx_valid", bus_a.rx_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
